// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C byte master.
package i2c_pkg;

    localparam int unsigned I2C_CLK_DIV_DEFAULT = 125;

    // Command codes on the cmd port; codes 5..7 are no-ops.
    typedef enum logic [2:0] {
        CmdStart   = 3'd0,
        CmdStop    = 3'd1,
        CmdWrite   = 3'd2,
        CmdReadAck = 3'd3,
        CmdReadNak = 3'd4
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStop,
        StData,
        StAck
    } i2c_state_e;

    // Byte-transfer flavour latched at command acceptance.
    typedef struct packed {
        logic is_read;  // 1 = READ_*, 0 = WRITE
        logic ack_low;  // master drives ACK low after a read byte
    } i2c_op_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period divider with clock-stretch freeze and 2-bit phase index.
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,      // start a new command at phase 0
    input  logic       run_i,       // a command is in progress
    input  logic       freeze_i,    // SCL released but held low by a slave
    output logic [1:0] phase_o,
    output logic       phase_end_o  // last cycle of the current phase
);

    localparam logic [15:0] Reload = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;

    assign phase_end_o = run_i & ~freeze_i & (cnt_q == '0);
    assign phase_o     = phase_q;

    // Count down each phase; hold everything while the clock is stretched.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            cnt_d   = Reload;
            phase_d = 2'd0;
        end else if (run_i && !freeze_i) begin
            if (cnt_q == '0) begin
                cnt_d   = Reload;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / STOP / WRITE / READ_ACK / READ_NAK commands.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int unsigned I2C_ADDR_WIDTH = 7,
    parameter int unsigned I2C_DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV        = I2C_CLK_DIV_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd,
    input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_nak,
    output logic                      bus_busy,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_low,
    output logic                      sda_low
);

    localparam int unsigned       W       = I2C_DATA_WIDTH;
    localparam int unsigned       BitCntW = $clog2(W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(W - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("CLK_DIV must lie in 2..65535");
    end
    if (W < 2) begin : g_bad_data_width
        $error("I2C_DATA_WIDTH must be at least 2");
    end
    if (I2C_ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("I2C_ADDR_WIDTH must be at least 1");
    end

    i2c_state_e         state_q, state_d;
    i2c_op_t            op_q, op_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               samp_q, samp_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_nak_q, rsp_nak_d;
    logic [W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic               bus_busy_q, bus_busy_d;

    logic       accept;
    logic       timer_load;
    logic       freeze;
    logic [1:0] phase;
    logic       phase_end;

    assign accept = cmd_valid & cmd_ready_q;
    // A released SCL that reads low is a slave stretching the clock.
    assign freeze = ~scl_low & ~scl_i;

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (timer_load),
        .run_i       (state_q != StIdle),
        .freeze_i    (freeze),
        .phase_o     (phase),
        .phase_end_o (phase_end)
    );

    // Bus line drive decoded from state and quarter phase.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state_q)
            StIdle: scl_low = bus_busy_q;
            StStart: begin
                unique case (phase)
                    2'd0: scl_low = bus_busy_q;
                    2'd1: ;
                    2'd2: sda_low = 1'b1;
                    2'd3: begin
                        scl_low = 1'b1;
                        sda_low = 1'b1;
                    end
                    default: ;
                endcase
            end
            StStop: begin
                unique case (phase)
                    2'd0: begin
                        scl_low = bus_busy_q;
                        sda_low = 1'b1;
                    end
                    2'd1: sda_low = 1'b1;
                    default: ;
                endcase
            end
            StData: begin
                scl_low = (phase == 2'd0) || (phase == 2'd3);
                sda_low = ~op_q.is_read & ~shift_q[W-1];
            end
            StAck: begin
                scl_low = (phase == 2'd0) || (phase == 2'd3);
                sda_low = op_q.is_read & op_q.ack_low;
            end
            default: ;
        endcase
    end

    // Command decode, bit sequencing and response generation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        rsp_valid_d = 1'b0;
        rsp_nak_d   = rsp_nak_q;
        rsp_rdata_d = rsp_rdata_q;
        bus_busy_d  = bus_busy_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    bit_cnt_d = '0;
                    case (cmd)
                        CmdStart: state_d = StStart;
                        CmdStop:  state_d = StStop;
                        CmdWrite: begin
                            state_d      = StData;
                            op_d.is_read = 1'b0;
                            op_d.ack_low = 1'b0;
                            shift_d      = cmd_wdata;
                        end
                        CmdReadAck: begin
                            state_d      = StData;
                            op_d.is_read = 1'b1;
                            op_d.ack_low = 1'b1;
                        end
                        CmdReadNak: begin
                            state_d      = StData;
                            op_d.is_read = 1'b1;
                            op_d.ack_low = 1'b0;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_nak_d   = 1'b0;
                        end
                    endcase
                end
            end
            StStart, StStop: begin
                if (phase_end && phase == 2'd3) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_nak_d   = 1'b0;
                    bus_busy_d  = (state_q == StStart);
                end
            end
            StData: begin
                if (phase_end && phase == 2'd2) begin
                    samp_d = sda_i;
                end
                if (phase_end && phase == 2'd3) begin
                    // Shift after SCL falls so the write bit stays stable through phase 3.
                    shift_d = {shift_q[W-2:0], samp_q};
                    if (bit_cnt_q == LastBit) begin
                        state_d = StAck;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StAck: begin
                if (phase_end && phase == 2'd2) begin
                    samp_d = sda_i;
                end
                if (phase_end && phase == 2'd3) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_nak_d   = op_q.is_read ? 1'b0 : samp_q;
                    if (op_q.is_read) begin
                        rsp_rdata_d = shift_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        timer_load  = accept && (state_d != StIdle);
        cmd_ready_d = (state_d == StIdle);
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_nak_q   <= 1'b0;
            rsp_rdata_q <= '0;
            bus_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_nak_q   <= rsp_nak_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_busy_q  <= bus_busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_nak   = rsp_nak_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: slave model, bus monitor and response scoreboard.
module tb_i2c_byte_master;
    import i2c_pkg::*;

    localparam int unsigned DIV = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd = 3'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nak;
    logic       bus_busy;
    logic       scl_i, sda_i, scl_low, sda_low;
    logic       slave_scl_hold = 1'b0;
    logic       slave_sda_low;

    always #5 clk = ~clk;

    assign scl_i = ~scl_low & ~slave_scl_hold;
    assign sda_i = ~sda_low & ~slave_sda_low;

    i2c_byte_master #(
        .I2C_ADDR_WIDTH (7),
        .I2C_DATA_WIDTH (8),
        .CLK_DIV        (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nak   (rsp_nak),
        .bus_busy  (bus_busy),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_low   (scl_low),
        .sda_low   (sda_low)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard of expected responses.
    typedef struct {
        logic       nak;
        logic       rd_chk;
        logic [7:0] rdata;
    } rsp_exp_t;
    rsp_exp_t sb_q[$];
    rsp_exp_t sb_e;
    int       rsp_seen = 0;

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_seen++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("rsp_nak", {31'd0, rsp_nak}, {31'd0, sb_e.nak});
                if (sb_e.rd_chk) check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, sb_e.rdata});
            end
        end
    end

    // Bus monitor: START/STOP conditions, SDA on SCL rise, slave bit index.
    logic scl_prev = 1'b1;
    logic sda_prev = 1'b1;
    int   cyc = 0;
    int   starts = 0;
    int   stops = 0;
    int   slv_idx = -1;
    logic bits_q[$];
    int   rise_t[$];

    always @(negedge clk) begin
        cyc++;
        if (scl_i && scl_prev && sda_prev && !sda_i) begin
            starts++;
            slv_idx = -1;
        end
        if (scl_i && scl_prev && !sda_prev && sda_i) stops++;
        if (scl_i && !scl_prev) begin
            bits_q.push_back(sda_i);
            rise_t.push_back(cyc);
        end
        if (!scl_i && scl_prev) slv_idx = (slv_idx + 1) % 9;
        scl_prev = scl_i;
        sda_prev = sda_i;
    end

    // Slave: 0 = absent, 1 = ACKs written bytes, 2 = transmits slv_tx.
    int         slv_mode = 0;
    logic [7:0] slv_tx = 8'h00;

    always_comb begin
        slave_sda_low = 1'b0;
        if (slv_mode == 1 && slv_idx == 8) slave_sda_low = 1'b1;
        else if (slv_mode == 2 && slv_idx >= 0 && slv_idx < 8) slave_sda_low = ~slv_tx[7-slv_idx];
    end

    function automatic logic [7:0] bits_to_byte();
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b[7-i] = bits_q[i];
        return b;
    endfunction

    task automatic send(input logic [2:0] c, input logic [7:0] d, input logic exp_nak,
                        input logic rd_chk, input logic [7:0] exp_rd, input bit wait_rsp,
                        output int lat);
        int       n;
        rsp_exp_t e;
        lat = -1;
        n   = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd       = c;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        e.nak     = exp_nak;
        e.rd_chk  = rd_chk;
        e.rdata   = exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!wait_rsp) return;
        n = 1;
        while (!rsp_valid && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
        else lat = n;
    endtask

    int   lat;
    int   st_n;
    int   seen0;
    logic [2:0] c_start, c_stop, c_write, c_rnak;

    initial begin
        c_start = CmdStart;
        c_stop  = CmdStop;
        c_write = CmdWrite;
        c_rnak  = CmdReadNak;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_scl_low", {31'd0, scl_low}, 32'd0);
        check_eq("rst_sda_low", {31'd0, sda_low}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
        check_eq("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        #1 check_eq("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 check_eq("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

        // START, WRITE 0x84 acked, STOP
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("busy_after_start", {31'd0, bus_busy}, 32'd1);
        check_eq("starts_1", starts, 32'd1);
        @(negedge clk);
        check_eq("idle_busy_scl_low", {31'd0, scl_low}, 32'd1);
        slv_mode = 1;
        bits_q.delete();
        rise_t.delete();
        send(c_write, 8'h84, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("w84_nbits", bits_q.size(), 32'd9);
        if (bits_q.size() == 9) begin
            check_eq("w84_bits", {24'd0, bits_to_byte()}, 32'h84);
            check_eq("w84_ackbit", {31'd0, bits_q[8]}, 32'd0);
            check_eq("w84_period_a", rise_t[1] - rise_t[0], 4 * DIV);
            check_eq("w84_period_b", rise_t[8] - rise_t[7], 4 * DIV);
        end
        slv_mode = 0;
        send(c_stop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("busy_after_stop", {31'd0, bus_busy}, 32'd0);
        check_eq("stops_1", stops, 32'd1);
        @(negedge clk);
        check_eq("idle_free_scl", {31'd0, scl_low}, 32'd0);
        check_eq("idle_free_sda", {31'd0, sda_low}, 32'd0);

        // WRITE 0x55 with no slave -> NAK
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        bits_q.delete();
        send(c_write, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, lat);
        if (bits_q.size() >= 8) check_eq("w55_bits", {24'd0, bits_to_byte()}, 32'h55);
        send(c_stop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);

        // READ_NAK of 0xA3
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        slv_mode = 1;
        send(c_write, 8'hA7, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        slv_mode = 2;
        slv_tx   = 8'hA3;
        bits_q.delete();
        send(c_rnak, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b1, lat);
        check_eq("rnak_nbits", bits_q.size(), 32'd9);
        if (bits_q.size() == 9) check_eq("rnak_ninth_released", {31'd0, bits_q[8]}, 32'd1);
        slv_mode = 0;
        send(c_stop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("rdata_holds", {24'd0, rsp_rdata}, 32'hA3);

        // Clock stretch of 500 cycles in bit 3
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        slv_mode = 1;
        bits_q.delete();
        rise_t.delete();
        fork
            send(c_write, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, lat);
            begin
                st_n = 0;
                while (slv_idx != 3 && st_n < 5000) begin
                    @(posedge clk);
                    st_n++;
                end
                #1 slave_scl_hold = 1'b1;
                repeat (500) @(posedge clk);
                #1 slave_scl_hold = 1'b0;
            end
        join
        check_eq("str_nbits", bits_q.size(), 32'd9);
        if (bits_q.size() == 9) begin
            check_eq("str_bits", {24'd0, bits_to_byte()}, 32'h3C);
            check_eq("str_delayed", {31'd0, (rise_t[3] - rise_t[2]) >= 500}, 32'd1);
            check_eq("str_resume_period", rise_t[4] - rise_t[3], 4 * DIV);
        end
        slv_mode = 0;
        send(c_stop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);

        // START, repeated START, STOP
        starts = 0;
        stops  = 0;
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("rs_starts", starts, 32'd2);
        check_eq("rs_no_stop", stops, 32'd0);
        check_eq("rs_busy", {31'd0, bus_busy}, 32'd1);
        send(c_stop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("rs_stops", stops, 32'd1);

        // Undefined command: no-op, response one cycle after acceptance
        send(3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        check_eq("noop_latency", lat, 32'd1);
        check_eq("noop_bus_idle", {31'd0, bus_busy}, 32'd0);

        // Reset mid-WRITE
        send(c_start, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, lat);
        slv_mode = 1;
        send(c_write, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, lat);
        repeat (8 * DIV + 3) @(negedge clk);
        seen0 = rsp_seen;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_scl", {31'd0, scl_low}, 32'd0);
        check_eq("mid_rst_sda", {31'd0, sda_low}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, bus_busy}, 32'd0);
        sb_q.delete();
        slv_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("mid_rst_ready_pre", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 check_eq("mid_rst_ready_post", {31'd0, cmd_ready}, 32'd1);
        repeat (100) @(negedge clk);
        check_eq("mid_rst_no_rsp", rsp_seen, seen0);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
